// File: rtl/rf_pkg.sv
// Shared register-file constants and writeback source indices.
package rf_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   // Writeback source slots on the arbiter request vector
   localparam int WB_SRC_ALU = 0;
   localparam int WB_SRC_LSU = 1;
   localparam int WB_SRC_CSR = 2;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request bus (sources -> arbiter) and register file write port.
interface rf_wb_if
   import rf_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = XLEN,
   parameter int ADDR_W  = REG_ADDR_W
) ();

   localparam int ID_W = $clog2(NUM_REQ);

   logic                       hold;
   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ*ADDR_W-1:0]  req_addr;
   logic [NUM_REQ*DATA_W-1:0]  req_data;
   logic [NUM_REQ-1:0]         req_ready;
   logic                       rf_we;
   logic [ADDR_W-1:0]          rf_addr;
   logic [DATA_W-1:0]          rf_wdata;
   logic [ID_W-1:0]            grant_id;
   logic                       dropped_x0;

   // Source side plus register file observer
   modport master (
      output hold, req_valid, req_addr, req_data,
      input  req_ready, rf_we, rf_addr, rf_wdata, grant_id, dropped_x0
   );

   // Arbiter side
   modport slave (
      input  hold, req_valid, req_addr, req_data,
      output req_ready, rf_we, rf_addr, rf_wdata, grant_id, dropped_x0
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting just after
// pointer, wrapping, and returns a one-hot grant plus its index.
module rr_arbiter #(
   parameter int N = 3,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] pointer,
   input  logic         enable,
   output logic [N-1:0] grant,
   output logic [W-1:0] index
);

   logic [W-1:0] cand;
   logic         found;

   // Pick the first requester after the pointer in circular order
   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves
      // it unassigned, which would otherwise infer a latch.
      grant = '0;
      index = '0;
      found = 1'b0;
      cand  = '0;
      for (int off = 1; off <= N; off++) begin
         cand = W'((int'(pointer) + off) % N);
         if (enable && !found && req[cand]) begin
            grant[cand] = 1'b1;
            index       = cand;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register file writeback arbiter: round-robin grant among NUM_REQ sources,
// one registered stage to the write port, writes to x0 filtered out.
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = XLEN,
   parameter int ADDR_W  = REG_ADDR_W
) (
   input  logic   clk,
   input  logic   rst_n,
   rf_wb_if.slave bus
);

   localparam int ID_W = $clog2(NUM_REQ);

   logic [ID_W-1:0]    last_grant;
   logic [ID_W-1:0]    sel_id;
   logic [NUM_REQ-1:0] grant;
   logic               handshake;
   logic               sel_is_x0;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_data;

   // Grants are suppressed while held or while reset is asserted
   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req     (bus.req_valid),
      .pointer (last_grant),
      .enable  (!bus.hold && rst_n),
      .grant   (grant),
      .index   (sel_id)
   );

   assign bus.req_ready = grant;
   assign handshake     = |grant;
   assign sel_addr      = bus.req_addr[int'(sel_id)*ADDR_W +: ADDR_W];
   assign sel_data      = bus.req_data[int'(sel_id)*DATA_W +: DATA_W];
   assign sel_is_x0     = (sel_addr == ADDR_W'(REG_ZERO));

   // Round-robin pointer follows the last accepted source
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n)
         last_grant <= ID_W'(NUM_REQ - 1);
      else if (handshake)
         last_grant <= sel_id;
   end

   // Output stage: register the winning write, discard x0 targets
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rf_we      <= 1'b0;
         bus.rf_addr    <= '0;
         bus.rf_wdata   <= '0;
         bus.grant_id   <= '0;
         bus.dropped_x0 <= 1'b0;
      end else begin
         bus.rf_we      <= handshake && !sel_is_x0;
         bus.dropped_x0 <= handshake && sel_is_x0;
         if (handshake && !sel_is_x0) begin
            bus.rf_addr  <= sel_addr;
            bus.rf_wdata <= sel_data;
            bus.grant_id <= sel_id;
         end
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus random
// traffic compared against a round-robin reference model.
module tb_rf_wb_arbiter;
   import rf_pkg::*;

   localparam int NR = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rf_wb_if #(.NUM_REQ(NR), .DATA_W(32), .ADDR_W(5)) bus ();

   rf_wb_arbiter #(.NUM_REQ(NR), .DATA_W(32), .ADDR_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Source stimulus
   logic          hold_i;
   logic [NR-1:0] vld;
   logic [4:0]    addr_q [NR];
   logic [31:0]   data_q [NR];

   assign bus.hold      = hold_i;
   assign bus.req_valid = vld;
   assign bus.req_addr  = {addr_q[2], addr_q[1], addr_q[0]};
   assign bus.req_data  = {data_q[2], data_q[1], data_q[0]};

   // Reference model state
   int          m_last;
   logic        m_we;
   logic        m_drop;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   int          m_gid;
   logic [NR-1:0] got_rdy;
   logic [31:0] rf_mem [32];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // First valid source after the last winner, circularly; -1 if none
   function automatic int model_winner();
      if (hold_i || !rst_n) return -1;
      for (int k = 1; k <= NR; k++) begin
         int i;
         i = (m_last + k) % NR;
         if (vld[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_last = NR - 1;
      m_we   = 1'b0;
      m_drop = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_gid  = 0;
   endtask

   // One clock: check grant before the edge, then the registered write after
   task automatic cycle();
      int w;
      logic [NR-1:0] exp_rdy;
      #1;
      w = model_winner();
      exp_rdy = (w >= 0) ? NR'(1 << w) : '0;
      got_rdy = bus.req_ready;
      check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      @(posedge clk);
      #1;
      m_we   = 1'b0;
      m_drop = 1'b0;
      if (w >= 0) begin
         m_last = w;
         if (addr_q[w] != 5'd0) begin
            m_we   = 1'b1;
            m_addr = addr_q[w];
            m_data = data_q[w];
            m_gid  = w;
         end else begin
            m_drop = 1'b1;
         end
      end
      check("rf_we", 64'(bus.rf_we), 64'(m_we));
      check("dropped_x0", 64'(bus.dropped_x0), 64'(m_drop));
      if (m_we) begin
         check("rf_addr", 64'(bus.rf_addr), 64'(m_addr));
         check("rf_wdata", 64'(bus.rf_wdata), 64'(m_data));
         check("grant_id", 64'(bus.grant_id), 64'(m_gid));
      end
      if (bus.rf_we === 1'b1) rf_mem[bus.rf_addr] = bus.rf_wdata;
   endtask

   task automatic do_reset();
      vld    = '0;
      hold_i = 1'b0;
      rst_n  = 1'b0;
      #1;
      check("rst_rf_we", 64'(bus.rf_we), 64'd0);
      #2;
      model_reset();
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf_mem[i] = '0;
      for (int i = 0; i < NR; i++) begin
         addr_q[i] = '0;
         data_q[i] = '0;
      end
      model_reset();
      rst_n  = 1'b0;
      hold_i = 1'b0;
      vld    = '1;

      // Reset state, including across a clock edge
      #2;
      check("rst_ready", 64'(bus.req_ready), 64'd0);
      check("rst_rf_addr", 64'(bus.rf_addr), 64'd0);
      check("rst_rf_wdata", 64'(bus.rf_wdata), 64'd0);
      check("rst_grant_id", 64'(bus.grant_id), 64'd0);
      check("rst_dropped", 64'(bus.dropped_x0), 64'd0);
      @(posedge clk);
      #1;
      check("rst_edge_rf_we", 64'(bus.rf_we), 64'd0);
      check("rst_edge_ready", 64'(bus.req_ready), 64'd0);

      // Single source
      do_reset();
      vld = 3'b010;
      addr_q[WB_SRC_LSU] = 5'd5;
      data_q[WB_SRC_LSU] = 32'hDEAD_BEEF;
      cycle();
      check("single_ready", 64'(got_rdy), 64'(3'b010));
      vld = '0;
      check("single_we", 64'(bus.rf_we), 64'd1);
      check("single_gid", 64'(bus.grant_id), 64'(WB_SRC_LSU));
      cycle();
      cycle();

      // Round-robin, all continuously valid
      do_reset();
      for (int i = 0; i < NR; i++) begin
         addr_q[i] = 5'(i + 1);
         data_q[i] = 32'h100 + 32'(i);
      end
      vld = '1;
      for (int k = 0; k < 6; k++) begin
         cycle();
         check("rr_order", 64'(got_rdy), 64'(1 << (k % NR)));
      end
      vld = '0;
      cycle();

      // Same address conflict: later grant's data is final
      do_reset();
      addr_q[WB_SRC_ALU] = 5'd7; data_q[WB_SRC_ALU] = 32'h11;
      addr_q[WB_SRC_CSR] = 5'd7; data_q[WB_SRC_CSR] = 32'h22;
      vld = 3'b101;
      cycle();
      check("conf_first", 64'(got_rdy), 64'(3'b001));
      vld = 3'b100;
      cycle();
      check("conf_second", 64'(got_rdy), 64'(3'b100));
      vld = '0;
      cycle();
      check("conf_x7", 64'(rf_mem[7]), 64'h22);

      // x0 drop, pointer still advances
      do_reset();
      addr_q[WB_SRC_ALU] = 5'd0; data_q[WB_SRC_ALU] = 32'hFFFF_FFFF;
      vld = 3'b001;
      cycle();
      vld = '0;
      check("x0_dropped", 64'(bus.dropped_x0), 64'd1);
      check("x0_no_we", 64'(bus.rf_we), 64'd0);
      addr_q[WB_SRC_ALU] = 5'd9;
      addr_q[WB_SRC_LSU] = 5'd10;
      vld = 3'b011;
      cycle();
      check("x0_tie_src1", 64'(got_rdy), 64'(3'b010));
      vld = '0;
      cycle();

      // hold: captured write still issues, no new grants
      do_reset();
      for (int i = 0; i < NR; i++) addr_q[i] = 5'(i + 1);
      vld = '1;
      cycle();
      hold_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cycle();
         check("hold_ready", 64'(got_rdy), 64'd0);
      end
      hold_i = 1'b0;
      cycle();
      check("hold_resume", 64'(got_rdy), 64'(3'b010));

      // Asynchronous reset with a captured write on the port
      do_reset();
      vld = '1;
      cycle();
      check("ar_pending_we", 64'(bus.rf_we), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_we_cleared", 64'(bus.rf_we), 64'd0);
      check("ar_ready_low", 64'(bus.req_ready), 64'd0);
      check("ar_addr_cleared", 64'(bus.rf_addr), 64'd0);
      model_reset();
      #2;
      rst_n = 1'b1;
      cycle();
      check("ar_first_src0", 64'(got_rdy), 64'(3'b001));

      // Random traffic against the model
      do_reset();
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NR; i++) begin
            if (!vld[i] && ($urandom_range(0, 1) == 1)) begin
               vld[i]    = 1'b1;
               addr_q[i] = 5'($urandom_range(0, 7));
               data_q[i] = $urandom;
            end
         end
         hold_i = ($urandom_range(0, 7) == 0);
         cycle();
         for (int i = 0; i < NR; i++)
            if (got_rdy[i]) vld[i] = 1'b0;
      end
      vld    = '0;
      hold_i = 1'b0;
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
